// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam int REDIRECT_FLUSH_DEF = 2;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    BUSY  = 2'd2
  } hz_state_t;

endpackage

// File: rtl/hz_sat_counter.sv
// Saturating up-counter with enable; sticks at all-ones, async active-low clear.
module hz_sat_counter #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Load-use / redirect / multi-cycle-busy hazard control for PC, IF/ID and ID/EXE.
// Performance counters are built only when HAZARD_PERF_EN is defined.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REDIRECT_FLUSH = REDIRECT_FLUSH_DEF,
  parameter int CNT_W          = 32
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  idValid,
  input  logic [REG_ADDR_W-1:0] idRs,
  input  logic [REG_ADDR_W-1:0] idRt,
  input  logic                  idUsesRs,
  input  logic                  idUsesRt,
  input  logic                  exeMemRead,
  input  logic                  exeRegShouldWrite,
  input  logic [REG_ADDR_W-1:0] exeRegWriteAddress,
  input  logic                  exeRedirect,
  input  logic                  exeBusy,
  output logic                  pcStall,
  output logic                  ifidStall,
  output logic                  ifidFlush,
  output logic                  idexeBubble
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0]      stallCount,
  output logic [CNT_W-1:0]      flushCount
`endif
);

  localparam logic [2:0] RELOAD = 3'(REDIRECT_FLUSH - 1);

  if ((REDIRECT_FLUSH < 1) || (REDIRECT_FLUSH > 7)) begin : g_bad_flush
    $error("REDIRECT_FLUSH must be within 1..7");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("CNT_W must be positive");
  end

  hz_state_t  state, stateNext;
  logic [2:0] flushLeft, flushLeftNext;
  logic       lu;

  assign lu = idValid & exeMemRead & exeRegShouldWrite & (exeRegWriteAddress != REG_ZERO) &
              ((idUsesRs & (idRs == exeRegWriteAddress)) |
               (idUsesRt & (idRt == exeRegWriteAddress)));

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state     <= RUN;
      flushLeft <= 3'd0;
    end else begin
      state     <= stateNext;
      flushLeft <= flushLeftNext;
    end
  end

  // Priority is redirect > busy > load-use; FLUSH discards decode so lu is ignored there.
  always_comb begin
    stateNext     = state;
    flushLeftNext = flushLeft;
    pcStall       = 1'b0;
    ifidStall     = 1'b0;
    ifidFlush     = 1'b0;
    idexeBubble   = 1'b0;
    case (state)
      FLUSH: begin
        ifidFlush   = 1'b1;
        idexeBubble = 1'b1;
        if (exeRedirect) begin
          flushLeftNext = RELOAD;
          stateNext     = (RELOAD == 3'd0) ? RUN : FLUSH;
        end else if (flushLeft <= 3'd1) begin
          flushLeftNext = 3'd0;
          stateNext     = RUN;
        end else begin
          flushLeftNext = flushLeft - 3'd1;
        end
      end
      default: begin
        if (exeRedirect) begin
          ifidFlush     = 1'b1;
          idexeBubble   = 1'b1;
          flushLeftNext = RELOAD;
          stateNext     = (RELOAD == 3'd0) ? RUN : FLUSH;
        end else if (exeBusy) begin
          pcStall   = 1'b1;
          ifidStall = 1'b1;
          stateNext = BUSY;
        end else begin
          stateNext = RUN;
          if (lu) begin
            pcStall     = 1'b1;
            ifidStall   = 1'b1;
            idexeBubble = 1'b1;
          end
        end
      end
    endcase
    // Keep ID/EXE empty and IF/ID flushed while reset is held.
    if (!Reset) begin
      pcStall     = 1'b0;
      ifidStall   = 1'b0;
      ifidFlush   = 1'b1;
      idexeBubble = 1'b1;
    end
  end

`ifdef HAZARD_PERF_EN
  hz_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .Reset (Reset),
    .en    (pcStall),
    .count (stallCount)
  );

  hz_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .CLK   (CLK),
    .Reset (Reset),
    .en    (ifidFlush & Reset),
    .count (flushCount)
  );
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl (REDIRECT_FLUSH=2); counter checks need HAZARD_PERF_EN.
module tb_pipe_hazard_ctrl;

  logic       CLK = 1'b0;
  logic       Reset;
  logic       idValid;
  logic [4:0] idRs, idRt;
  logic       idUsesRs, idUsesRt;
  logic       exeMemRead, exeRegShouldWrite;
  logic [4:0] exeRegWriteAddress;
  logic       exeRedirect, exeBusy;
  logic       pcStall, ifidStall, ifidFlush, idexeBubble;
`ifdef HAZARD_PERF_EN
  logic [3:0] stallCount, flushCount;
`endif

  typedef struct packed {
    logic       rst;
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       usesRs;
    logic       usesRt;
    logic       memRead;
    logic       regWrite;
    logic [4:0] wAddr;
    logic       redirect;
    logic       busy;
  } stim_t;

  typedef struct {
    logic [3:0] outs;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // {pcStall, ifidStall, ifidFlush, idexeBubble}
  wire [3:0] obs = {pcStall, ifidStall, ifidFlush, idexeBubble};

  pipe_hazard_ctrl #(
    .REDIRECT_FLUSH (2),
    .CNT_W          (4)
  ) dut (
    .CLK                (CLK),
    .Reset              (Reset),
    .idValid            (idValid),
    .idRs               (idRs),
    .idRt               (idRt),
    .idUsesRs           (idUsesRs),
    .idUsesRt           (idUsesRt),
    .exeMemRead         (exeMemRead),
    .exeRegShouldWrite  (exeRegShouldWrite),
    .exeRegWriteAddress (exeRegWriteAddress),
    .exeRedirect        (exeRedirect),
    .exeBusy            (exeBusy),
    .pcStall            (pcStall),
    .ifidStall          (ifidStall),
    .ifidFlush          (ifidFlush),
    .idexeBubble        (idexeBubble)
`ifdef HAZARD_PERF_EN
    ,
    .stallCount         (stallCount),
    .flushCount         (flushCount)
`endif
  );

  always #5 CLK = ~CLK;

  function automatic stim_t mk(logic rst, logic valid, logic [4:0] rs, logic [4:0] rt,
                               logic usesRs, logic usesRt, logic memRead, logic regWrite,
                               logic [4:0] wAddr, logic redirect, logic busy);
    stim_t s;
    s = '{rst, valid, rs, rt, usesRs, usesRt, memRead, regWrite, wAddr, redirect, busy};
    return s;
  endfunction

  function automatic stim_t idleS();
    return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  // Load writing r8 in ID/EXE, decode reading rs=r8.
  function automatic stim_t luS();
    return mk(1, 1, 5'd8, 5'd1, 1, 0, 1, 1, 5'd8, 0, 0);
  endfunction

  function automatic stim_t withCtl(stim_t s, logic rst, logic redirect, logic busy);
    stim_t r;
    r          = s;
    r.rst      = rst;
    r.redirect = redirect;
    r.busy     = busy;
    return r;
  endfunction

  task automatic applyStim(input stim_t s);
    Reset              = s.rst;
    idValid            = s.valid;
    idRs               = s.rs;
    idRt               = s.rt;
    idUsesRs           = s.usesRs;
    idUsesRt           = s.usesRt;
    exeMemRead         = s.memRead;
    exeRegShouldWrite  = s.regWrite;
    exeRegWriteAddress = s.wAddr;
    exeRedirect        = s.redirect;
    exeBusy            = s.busy;
  endtask

  // Drive one cycle just after the rising edge, queue its expectation, stop at the falling edge.
  task automatic driveCycle(input stim_t s, input logic [3:0] e, input string tag);
    exp_t x;
    @(posedge CLK);
    #1;
    applyStim(s);
    x.outs = e;
    x.tag  = tag;
    sb.push_back(x);
    @(negedge CLK);
  endtask

  task automatic test_reset();
    stim_t      st[$];
    logic [3:0] ex[$];
    exp_t       e;
    st.push_back(withCtl(idleS(), 0, 0, 0));  ex.push_back(4'b0011);
    st.push_back(withCtl(luS(),   0, 0, 1));  ex.push_back(4'b0011);
    st.push_back(withCtl(idleS(), 0, 1, 0));  ex.push_back(4'b0011);
    st.push_back(idleS());                    ex.push_back(4'b0000);
    for (int i = 0; i < st.size(); i++) begin
      driveCycle(st[i], ex[i], $sformatf("reset[%0d]", i));
      e = sb.pop_front();
      checks++;
      if (obs !== e.outs) begin
        errors++;
        $display("[TB] FAIL %s got=%b expected=%b", e.tag, obs, e.outs);
      end
    end
  endtask

  task automatic test_load_use();
    stim_t      st[$];
    logic [3:0] ex[$];
    exp_t       e;
    st.push_back(luS());                                         ex.push_back(4'b1101);
    st.push_back(mk(1, 1, 5'd8, 5'd1, 1, 0, 0, 1, 5'd8, 0, 0));  ex.push_back(4'b0000);
    st.push_back(mk(1, 1, 5'd3, 5'd8, 1, 1, 1, 1, 5'd8, 0, 0));  ex.push_back(4'b1101);
    st.push_back(mk(1, 1, 5'd0, 5'd0, 1, 1, 1, 1, 5'd0, 0, 0));  ex.push_back(4'b0000);
    st.push_back(mk(1, 1, 5'd8, 5'd1, 0, 0, 1, 1, 5'd8, 0, 0));  ex.push_back(4'b0000);
    st.push_back(mk(1, 0, 5'd8, 5'd1, 1, 0, 1, 1, 5'd8, 0, 0));  ex.push_back(4'b0000);
    st.push_back(mk(1, 1, 5'd8, 5'd1, 1, 0, 1, 0, 5'd8, 0, 0));  ex.push_back(4'b0000);
    st.push_back(mk(1, 1, 5'd9, 5'd1, 1, 0, 1, 1, 5'd8, 0, 0));  ex.push_back(4'b0000);
    for (int i = 0; i < st.size(); i++) begin
      driveCycle(st[i], ex[i], $sformatf("load_use[%0d]", i));
      e = sb.pop_front();
      checks++;
      if (obs !== e.outs) begin
        errors++;
        $display("[TB] FAIL %s got=%b expected=%b", e.tag, obs, e.outs);
      end
    end
  endtask

  task automatic test_redirect();
    stim_t      st[$];
    logic [3:0] ex[$];
    exp_t       e;
    st.push_back(withCtl(idleS(), 1, 1, 0));  ex.push_back(4'b0011);
    st.push_back(idleS());                    ex.push_back(4'b0011);
    st.push_back(idleS());                    ex.push_back(4'b0000);
    st.push_back(withCtl(idleS(), 1, 1, 0));  ex.push_back(4'b0011);
    st.push_back(withCtl(idleS(), 1, 1, 0));  ex.push_back(4'b0011);
    st.push_back(luS());                      ex.push_back(4'b0011);
    st.push_back(luS());                      ex.push_back(4'b1101);
    st.push_back(withCtl(luS(),   1, 1, 1));  ex.push_back(4'b0011);
    st.push_back(withCtl(idleS(), 1, 0, 1));  ex.push_back(4'b0011);
    st.push_back(idleS());                    ex.push_back(4'b0000);
    for (int i = 0; i < st.size(); i++) begin
      driveCycle(st[i], ex[i], $sformatf("redirect[%0d]", i));
      e = sb.pop_front();
      checks++;
      if (obs !== e.outs) begin
        errors++;
        $display("[TB] FAIL %s got=%b expected=%b", e.tag, obs, e.outs);
      end
      checks++;
      if (ifidStall && ifidFlush) begin
        errors++;
        $display("[TB] FAIL %s_overlap got stall=%b flush=%b expected not both 1",
                 e.tag, ifidStall, ifidFlush);
      end
    end
  endtask

  task automatic test_busy();
    stim_t      st[$];
    logic [3:0] ex[$];
    exp_t       e;
    for (int i = 0; i < 3; i++) begin
      st.push_back(withCtl(luS(), 1, 0, 1));  ex.push_back(4'b1100);
    end
    st.push_back(luS());                      ex.push_back(4'b1101);
    st.push_back(idleS());                    ex.push_back(4'b0000);
    st.push_back(withCtl(idleS(), 1, 0, 1));  ex.push_back(4'b1100);
    st.push_back(withCtl(idleS(), 1, 1, 1));  ex.push_back(4'b0011);
    st.push_back(idleS());                    ex.push_back(4'b0011);
    st.push_back(idleS());                    ex.push_back(4'b0000);
    for (int i = 0; i < st.size(); i++) begin
      driveCycle(st[i], ex[i], $sformatf("busy[%0d]", i));
      e = sb.pop_front();
      checks++;
      if (obs !== e.outs) begin
        errors++;
        $display("[TB] FAIL %s got=%b expected=%b", e.tag, obs, e.outs);
      end
    end
  endtask

  // Two redirects leave FLUSH pending past the next edge; reset mid-cycle must cancel it.
  task automatic test_reset_mid_flush();
    exp_t e;
    driveCycle(withCtl(idleS(), 1, 1, 0), 4'b0011, "midflush_redirect0");
    e = sb.pop_front();
    checks++;
    if (obs !== e.outs) begin
      errors++;
      $display("[TB] FAIL %s got=%b expected=%b", e.tag, obs, e.outs);
    end
    driveCycle(withCtl(idleS(), 1, 1, 0), 4'b0011, "midflush_redirect1");
    e = sb.pop_front();
    checks++;
    if (obs !== e.outs) begin
      errors++;
      $display("[TB] FAIL %s got=%b expected=%b", e.tag, obs, e.outs);
    end
    #1;
    applyStim(withCtl(luS(), 0, 0, 1));
    e.outs = 4'b0011;
    e.tag  = "midflush_in_reset";
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    checks++;
    if (obs !== e.outs) begin
      errors++;
      $display("[TB] FAIL %s got=%b expected=%b", e.tag, obs, e.outs);
    end
    driveCycle(idleS(), 4'b0000, "midflush_after_release");
    e = sb.pop_front();
    checks++;
    if (obs !== e.outs) begin
      errors++;
      $display("[TB] FAIL %s got=%b expected=%b", e.tag, obs, e.outs);
    end
    driveCycle(luS(), 4'b1101, "midflush_run_lu");
    e = sb.pop_front();
    checks++;
    if (obs !== e.outs) begin
      errors++;
      $display("[TB] FAIL %s got=%b expected=%b", e.tag, obs, e.outs);
    end
  endtask

`ifdef HAZARD_PERF_EN
  task automatic test_perf();
    driveCycle(withCtl(idleS(), 0, 0, 0), 4'b0011, "perf_reset");
    void'(sb.pop_front());
    checks++;
    if (stallCount !== 4'd0 || flushCount !== 4'd0) begin
      errors++;
      $display("[TB] FAIL perf_reset_clear got=%0d/%0d expected=0/0", stallCount, flushCount);
    end
    for (int i = 0; i < 20; i++) begin
      driveCycle(withCtl(idleS(), 1, 0, 1), 4'b1100, "perf_busy");
      void'(sb.pop_front());
    end
    driveCycle(idleS(), 4'b0000, "perf_idle");
    void'(sb.pop_front());
    checks++;
    if (stallCount !== 4'd15 || flushCount !== 4'd0) begin
      errors++;
      $display("[TB] FAIL perf_stall_sat got=%0d/%0d expected=15/0", stallCount, flushCount);
    end
    driveCycle(withCtl(idleS(), 1, 1, 0), 4'b0011, "perf_redirect");
    void'(sb.pop_front());
    driveCycle(idleS(), 4'b0011, "perf_flush");
    void'(sb.pop_front());
    driveCycle(idleS(), 4'b0000, "perf_idle2");
    void'(sb.pop_front());
    checks++;
    if (stallCount !== 4'd15 || flushCount !== 4'd2) begin
      errors++;
      $display("[TB] FAIL perf_flush_count got=%0d/%0d expected=15/2", stallCount, flushCount);
    end
    #1;
    Reset = 1'b0;
    #1;
    checks++;
    if (stallCount !== 4'd0 || flushCount !== 4'd0) begin
      errors++;
      $display("[TB] FAIL perf_async_clear got=%0d/%0d expected=0/0", stallCount, flushCount);
    end
    driveCycle(idleS(), 4'b0000, "perf_release");
    void'(sb.pop_front());
  endtask
`endif

  initial begin
    applyStim(withCtl(idleS(), 0, 0, 0));
    test_reset();
    test_load_use();
    test_redirect();
    test_busy();
    test_reset_mid_flush();
`ifdef HAZARD_PERF_EN
    test_perf();
`endif
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain got=%0d expected=0 pending", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard controller that drives the ID/EXE pipeline register's bubble input (`Reset_in`) and the stall/flush controls of the PC and IF/ID register. It compares decode-stage source registers against the instruction held in the ID/EXE register to detect load-use hazards. It holds a flush window after a redirect (jump or taken branch) resolved in EXE, and stalls while a multi-cycle EXE unit is busy. It sits between ID and EXE as the control source for that register; stall and flush decisions are combinational, and flush/stall windows are sequential.

## Interface
Parameters:
- `REDIRECT_FLUSH`, default 2: number of consecutive cycles of bubble and IF/ID flush per redirect; legal range 1–7.
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `CLK`, in, 1: sole clock; all state updates on the rising edge.
- `Reset`, in, 1: asynchronous, active-low reset.
- `idValid`, in, 1: the IF/ID register holds a real instruction.
- `idRs`, `idRt`, in, 5 each: decode-stage source register addresses.
- `idUsesRs`, `idUsesRt`, in, 1 each: decode actually reads that source.
- `exeMemRead`, in, 1: the ID/EXE register holds a load.
- `exeRegShouldWrite`, in, 1: the ID/EXE instruction writes the register file.
- `exeRegWriteAddress`, in, 5: destination register of the ID/EXE instruction.
- `exeRedirect`, in, 1: EXE resolved a jump or taken branch this cycle (`PCSrc_jump`/`PCSrc_branch` nonzero).
- `exeBusy`, in, 1: a multi-cycle EXE unit needs more cycles.
- `pcStall`, out, 1: hold the PC.
- `ifidStall`, out, 1: hold the IF/ID register.
- `ifidFlush`, out, 1: load IF/ID with a bubble.
- `idexeBubble`, out, 1: connects to `Reset_in` of the ID/EXE register; 1 inserts a bubble.
- `stallCount`, `flushCount`, out, `CNT_W`: performance counters. Present only with `HAZARD_PERF_EN`.

## Operation
- FSM states:
  - RUN: normal issue.
  - FLUSH: redirect window active; `flushLeft` counter is 3 bits.
  - BUSY: EXE unit stall.
- Load-use hazard `lu` = `idValid & exeMemRead & exeRegShouldWrite & (exeRegWriteAddress != 0) & ((idUsesRs & idRs == exeRegWriteAddress) | (idUsesRt & idRt == exeRegWriteAddress))`.
- Priority when events coincide: redirect > busy > load-use.
- Redirect:
  - Effect in the same cycle: `ifidFlush=1`, `idexeBubble=1`, `pcStall=0`.
  - Next state is FLUSH with `flushLeft=REDIRECT_FLUSH-1`; if `REDIRECT_FLUSH==1`, next state is RUN.
- In FLUSH:
  - `ifidFlush=1` and `idexeBubble=1`; `flushLeft` decrements each cycle; transition to RUN when `flushLeft==1` at the edge.
  - A new `exeRedirect` while in FLUSH reloads `flushLeft` to `REDIRECT_FLUSH-1`.
  - `lu` is ignored, because the decode instruction is being discarded.
- `exeBusy` in RUN or BUSY:
  - Outputs: `pcStall=1`, `ifidStall=1`, `idexeBubble=0`; the ID/EXE register holds and is not bubbled.
  - State is BUSY while `exeBusy` stays high, then RUN.
- Load-use in RUN:
  - Outputs: `pcStall=1`, `ifidStall=1`, `idexeBubble=1` for exactly that cycle.
  - Next cycle the load is in MEM, so `lu` drops naturally; no extra state is needed.
- `idexeBubble` is forced to 1 whenever `Reset` is low, so the ID/EXE register stays empty during reset.

## Timing
- Reset (async, `Reset=0`):
  - Sequential state: state=RUN, `flushLeft=0`, counters=0.
  - Outputs: `pcStall=0`, `ifidStall=0`, `ifidFlush=1`, `idexeBubble=1`.
- Stall, bubble and flush outputs are combinational from the current inputs and state, with zero-cycle latency, so they reach the register enables before the same rising edge.
- A redirect yields exactly `REDIRECT_FLUSH` bubble cycles, counting the redirect cycle, unless another redirect extends the window.
- Reset asserted mid-FLUSH aborts the window immediately. The first cycle after `Reset` rises is RUN.
- Outputs never glitch-combine: `ifidStall` and `ifidFlush` are never both 1. Flush wins.

## Configuration
- `HAZARD_PERF_EN` defined:
  - `stallCount` increments on each cycle with `pcStall=1`.
  - `flushCount` increments on each cycle with `ifidFlush=1`, excluding reset.
  - Both saturate at all-ones and clear on reset.
- Not defined: the counter ports and logic are absent; all other behaviour is identical.

## Structure
- Shared package `pipe_pkg`:
  - State enum `hz_state_t` (RUN/FLUSH/BUSY).
  - `REG_ADDR_W=5`, `REG_ZERO=5'd0`.
  - Default `REDIRECT_FLUSH`.
- One sub-module `hz_sat_counter`: a saturating counter with an enable, instantiated twice under `HAZARD_PERF_EN`.

## Test plan
- Load at ID/EXE writing r8, decode reads rs=r8 with `idUsesRs=1` → for one cycle `pcStall=1`, `ifidStall=1`, `idexeBubble=1`; the next cycle all are 0.
- Same as above but `exeRegWriteAddress=0` or `idUsesRs=0` → no stall.
- `exeRedirect` pulse with `REDIRECT_FLUSH=2` → `ifidFlush` and `idexeBubble` high for 2 cycles, then RUN. A second redirect in cycle 2 extends the window to cycle 3.
- `exeBusy` high for 3 cycles together with `lu` → `pcStall`/`ifidStall` high for 3 cycles with `idexeBubble=0`, then the load-use bubble appears if `lu` persists.
- Reset dropped mid-FLUSH → outputs take their reset values immediately; after release, state is RUN with no residual flush.
- With `HAZARD_PERF_EN` and `CNT_W=4`, 20 stall cycles → `stallCount=15` (saturated); reset → 0.
